// File: rtl/uart_axil_master.sv
// uart_axil_master: decodes UART byte commands into single-beat AXI-lite reads/writes
// and returns a status byte (plus read data) through the UART transmitter.
module uart_axil_master #(
    parameter int GAP_CYCLES = 1000000,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_en,
    input  logic              tx_done,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, AXI_W, AXI_B, AXI_AR, AXI_R, RSP} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [39:0]       out_q, out_d;
    logic [2:0]        rem_q, rem_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            gap_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            out_q     <= '0;
            rem_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            out_q     <= out_d;
            rem_q     <= rem_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        data_d    = data_q;
        out_d     = out_q;
        rem_d     = rem_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: if (rx_valid) begin
                cnt_d = '0;
                gap_d = '0;
                wr_d  = rx_data == 8'h57;
                if (rx_data == 8'h57 || rx_data == 8'h52) begin
                    state_d = ADDR;
                end else begin
                    state_d = RSP;
                    out_d   = {8'h3F, 32'h0};
                    rem_d   = 3'd1;
                end
            end
            ADDR, DATA: begin
                gap_d = rx_valid ? '0 : gap_q + GW'(1);
                if (rx_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ADDR) addr_d = {addr_q[ADDR_W-9:0], rx_data};
                    else data_d = {data_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        if (state_q == DATA) begin
                            state_d   = AXI_W;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            state_d = wr_q ? DATA : AXI_AR;
                        end
                    end
                end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            AXI_W: begin
                // each channel retires on its own handshake; leave once neither is pending
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready) wvalid_d = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_d = AXI_B;
            end
            AXI_B: if (m_axi_bvalid) begin
                state_d = RSP;
                out_d   = {(m_axi_bresp == 2'b00) ? 8'h4B : 8'h45, 32'h0};
                rem_d   = 3'd1;
            end
            AXI_AR: if (m_axi_arready) state_d = AXI_R;
            AXI_R: if (m_axi_rvalid) begin
                state_d = RSP;
                out_d   = {(m_axi_rresp == 2'b00) ? 8'h4B : 8'h45, m_axi_rdata};
                rem_d   = (m_axi_rresp == 2'b00) ? 3'd5 : 3'd1;
            end
            RSP: if (tx_done && !tx_en_q) begin
                tx_en_d   = 1'b1;
                tx_data_d = out_q[39:32];
                out_d     = {out_q[31:0], 8'h0};
                rem_d     = rem_q - 3'd1;
                if (rem_q == 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_en         = 1'b1;
    assign tx_en         = tx_en_q;
    assign tx_data       = tx_data_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = state_q == AXI_B;
    assign m_axi_arvalid = state_q == AXI_AR;
    assign m_axi_rready  = state_q == AXI_R;
endmodule

// File: tb/tb_uart_axil_master.sv
// tb_uart_axil_master: command vectors driven over the rx byte port, AXI-lite subordinate
// model with configurable delays, expected tx bytes scoreboarded in a queue.
module tb_uart_axil_master;
    localparam int GAP = 16;

    logic        clk, rst_n;
    logic        rx_valid, rx_en, tx_done, tx_en;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    uart_axil_master #(.GAP_CYCLES(GAP), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_en(rx_en),
        .tx_done(tx_done), .tx_en(tx_en), .tx_data(tx_data),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ad;
        int          dd;
        logic [7:0]  st;
    } vec_t;

    vec_t        vecs[8];
    logic [7:0]  exp_q[$];
    int          checks = 0, errors = 0;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = 32'h0;
    bit          b_hold = 1'b0;
    int          awc = 0, wc = 0, arc = 0, rc = 0, busy = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, nv = 0, viol = 0;
    logic [31:0] aw_first, w_first, ar_first, got_aw, got_w, got_ar;
    logic [3:0]  got_ws;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    // AXI-lite subordinate: ready after a programmable wait, flags valid drops or payload changes
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
                awc = 0; wc = 0; arc = 0; rc = 0;
            end else begin
                if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) nv++;
                if (m_axi_awready) begin m_axi_awready = 0; awc = 0; end
                else if (m_axi_awvalid) begin
                    if (awc == 0) aw_first = m_axi_awaddr; else if (m_axi_awaddr !== aw_first) viol++;
                    if (awc == aw_dly) begin m_axi_awready = 1; got_aw = m_axi_awaddr; n_aw++; end
                    else awc++;
                end else if (awc != 0) viol++;
                if (m_axi_wready) begin m_axi_wready = 0; wc = 0; end
                else if (m_axi_wvalid) begin
                    if (wc == 0) w_first = m_axi_wdata; else if (m_axi_wdata !== w_first) viol++;
                    if (wc == w_dly) begin m_axi_wready = 1; got_w = m_axi_wdata; got_ws = m_axi_wstrb; n_w++; end
                    else wc++;
                end else if (wc != 0) viol++;
                if (m_axi_arready) begin m_axi_arready = 0; arc = 0; end
                else if (m_axi_arvalid) begin
                    if (arc == 0) ar_first = m_axi_araddr; else if (m_axi_araddr !== ar_first) viol++;
                    if (arc == ar_dly) begin m_axi_arready = 1; got_ar = m_axi_araddr; n_ar++; end
                    else arc++;
                end else if (arc != 0) viol++;
                if (m_axi_bvalid) m_axi_bvalid = 0;
                else if (m_axi_bready && !b_hold) begin m_axi_bvalid = 1; m_axi_bresp = b_resp; end
                if (m_axi_rvalid) begin m_axi_rvalid = 0; rc = 0; end
                else if (m_axi_rready) begin
                    if (rc == r_dly) begin m_axi_rvalid = 1; m_axi_rdata = r_data; m_axi_rresp = r_resp; end
                    else rc++;
                end
            end
        end
    end

    // Transmitter model: busy for a few cycles after each launch; every launch pops the scoreboard
    initial begin
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_done = 1'b1; busy = 0;
            end else if (tx_en) begin
                chk("tx_gate", 40'(tx_done), 40'(1));
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_extra got %h expected no byte", tx_data);
                end else chk("tx_byte", 40'(tx_data), 40'(exp_q.pop_front()));
                tx_done = 1'b0; busy = 3;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) tx_done = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin @(negedge clk); t++; end
        chk("drain", 40'(exp_q.size()), 40'(0));
        exp_q.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int aw0 = n_aw, w0 = n_w, ar0 = n_ar, nv0 = nv;
        aw_dly = v.ad; ar_dly = v.ad; w_dly = v.dd; r_dly = v.dd;
        b_resp = v.resp; r_resp = v.resp; r_data = v.data;
        exp_q.push_back(v.st);
        if (v.op == 8'h52 && v.st == 8'h4B) for (int i = 3; i >= 0; i--) exp_q.push_back(v.data[i*8+:8]);
        send(v.op);
        if (v.op == 8'h57 || v.op == 8'h52) for (int i = 3; i >= 0; i--) send(v.addr[i*8+:8]);
        if (v.op == 8'h57) for (int i = 3; i >= 0; i--) send(v.data[i*8+:8]);
        drain();
        if (v.op == 8'h57) begin
            chk("awaddr", 40'(got_aw), 40'(v.addr));
            chk("wdata", 40'(got_w), 40'(v.data));
            chk("wstrb", 40'(got_ws), 40'(4'hF));
            chk("aw_count", 40'(n_aw - aw0), 40'(1));
            chk("w_count", 40'(n_w - w0), 40'(1));
        end else if (v.op == 8'h52) begin
            chk("araddr", 40'(got_ar), 40'(v.addr));
            chk("ar_count", 40'(n_ar - ar0), 40'(1));
        end else chk("no_axi", 40'(nv - nv0), 40'(0));
    endtask

    initial begin
        int t, nv0;
        vecs[0] = '{8'h57, 32'h10000004, 32'h0000000A, 2'b00, 3, 3, 8'h4B};
        vecs[1] = '{8'h52, 32'h10000004, 32'h12345678, 2'b00, 0, 2, 8'h4B};
        vecs[2] = '{8'h57, 32'h20000000, 32'hDEADBEEF, 2'b11, 0, 0, 8'h45};
        vecs[3] = '{8'h52, 32'h20000010, 32'hCAFEF00D, 2'b10, 1, 1, 8'h45};
        vecs[4] = '{8'h41, 32'h0,        32'h0,        2'b00, 0, 0, 8'h3F};
        vecs[5] = '{8'h52, 32'h10000004, 32'h12345678, 2'b00, 0, 0, 8'h4B};
        vecs[6] = '{8'h57, 32'h3000000C, 32'hA5A55A5A, 2'b00, 0, 3, 8'h4B};
        vecs[7] = '{8'h57, 32'h3000000C, 32'h11223344, 2'b01, 2, 0, 8'h45};
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 40'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, tx_en}), 40'(0));
        chk("rst_awaddr", 40'(m_axi_awaddr), 40'(0));
        chk("rst_araddr", 40'(m_axi_araddr), 40'(0));
        chk("rst_wdata", 40'(m_axi_wdata), 40'(0));
        chk("rst_tx_data", 40'(tx_data), 40'(0));
        chk("rst_rx_en", 40'(rx_en), 40'(1));
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        // partial read frame abandoned after the gap; the next write must parse from its opcode
        nv0 = nv;
        send(8'h52); send(8'h10); send(8'h00);
        repeat (GAP + 8) @(negedge clk);
        chk("gap_no_axi", 40'(nv - nv0), 40'(0));
        run_vec(vecs[0]);
        // reset while waiting for the write response
        b_hold = 1'b1; aw_dly = 0; w_dly = 0;
        send(8'h57);
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
        t = 0;
        while (!m_axi_bready && t < 100) begin @(negedge clk); t++; end
        chk("reach_axi_b", 40'(m_axi_bready), 40'(1));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 40'({m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, tx_en}), 40'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; b_hold = 1'b0;
        run_vec(vecs[1]);
        chk("valid_hold", 40'(viol), 40'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
